simple_bfm_rsp: RTL

- Responder (target) end of the req/ack/data four-phase handshake driven by simple_bfm.
- Replaces the one-flop `ack` echo in the testbench top with a real responder. It applies a programmable ack delay and buffers captured bytes in a small FIFO.
- It backpressures the initiator by withholding ack when the FIFO is full.
- Captured bytes leave on a valid/ready stream for the checker or scoreboard side.

---
 rtl/simple_bfm_pkg.sv | 13 +
 rtl/simple_bfm_rsp_if.sv | 24 ++
 rtl/simple_bfm_rsp_fifo.sv | 58 +++++
 rtl/simple_bfm_rsp.sv | 105 ++++++++++
 4 files changed

// File: rtl/simple_bfm_pkg.sv
// Shared types and width defaults for the simple_bfm initiator/responder pair.
package simple_bfm_pkg;

  localparam int SIMPLE_BFM_DATA_W = 8;
  localparam int SIMPLE_BFM_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } rsp_state_e;

endpackage

// File: rtl/simple_bfm_rsp_if.sv
// Handshake (req/data/ack) plus the captured-byte valid/ready stream.
// The master side is the initiator, which also consumes the stream.
interface simple_bfm_rsp_if #(
  parameter int DATA_W = 8
) ();

  logic              req;
  logic [DATA_W-1:0] data;
  logic              ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output req, data, out_ready,
    input  ack, out_valid, out_data
  );

  modport slave (
    input  req, data, out_ready,
    output ack, out_valid, out_data
  );

endinterface

// File: rtl/simple_bfm_rsp_fifo.sv
// Synchronous first-word fall-through FIFO buffering captured handshake bytes.
module simple_bfm_rsp_fifo #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the push writes into.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LW'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/simple_bfm_rsp.sv
// Responder end of the simple_bfm four-phase handshake: programmable ack delay,
// capture FIFO with backpressure, and a valid/ready output stream.
module simple_bfm_rsp
  import simple_bfm_pkg::*;
#(
  parameter  int DATA_W     = SIMPLE_BFM_DATA_W,
  parameter  int FIFO_DEPTH = 4,
  parameter  int ACK_DLY    = 1,
  parameter  int CNT_W      = SIMPLE_BFM_CNT_W,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1,
  localparam int DLY_W      = (ACK_DLY > 2) ? $clog2(ACK_DLY - 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  simple_bfm_rsp_if.slave      bus,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [CNT_W-1:0]     xfer_count,
  output logic                 protocol_err
);

  localparam int DLY_LOAD = (ACK_DLY > 1) ? (ACK_DLY - 2) : 0;

  rsp_state_e        state;
  logic [DLY_W-1:0]  dly_cnt;
  logic              ack_q;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  // Capture happens on the same edge that registers ack high.
  assign push = bus.req &&
                (((state == IDLE) && !fifo_full && (ACK_DLY == 1)) ||
                 ((state == WAIT) && (dly_cnt == '0)));

  assign bus.ack       = ack_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dly_cnt      <= '0;
      ack_q        <= 1'b0;
      protocol_err <= 1'b0;
      xfer_count   <= '0;
    end else begin
      protocol_err <= 1'b0;
      if (push) begin
        xfer_count <= xfer_count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          // Full is judged on the registered level, so a same-edge pop does not help.
          if (bus.req && !fifo_full) begin
            if (ACK_DLY == 1) begin
              ack_q <= 1'b1;
              state <= ACK;
            end else begin
              dly_cnt <= DLY_W'(DLY_LOAD);
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!bus.req) begin
            protocol_err <= 1'b1;
            state        <= IDLE;
          end else if (dly_cnt == '0) begin
            ack_q <= 1'b1;
            state <= ACK;
          end else begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end
        end
        ACK: begin
          if (!bus.req) begin
            ack_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  simple_bfm_rsp_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.data),
    .pop       (bus.out_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule
